pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 181 ++++++++++++++++++
 tb/tb_pipelined_adder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor with a valid/ready handshake on both sides.
// Each pipeline stage adds one WIDTH/STAGES-bit slice with 4-bit
// carry-lookahead groups and registers its slice carry for the next stage.
// Optional macro PIPELINED_ADDER_SAT_EN adds a 'sat' input that clamps signed
// overflow to the signed limit.
module pipelined_adder #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef PIPELINED_ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    localparam int unsigned SW     = WIDTH / STAGES;
    localparam int unsigned GROUPS = SW / 4;

    // Stage state; stage k holds operands, partial sum and the carry out of slice k
    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic              c_q   [STAGES];
    logic              ov_q  [STAGES];
    logic              sat_q [STAGES];

    // Per-stage inputs and computed next values
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_b   [STAGES];
    logic [WIDTH-1:0]  src_s   [STAGES];
    logic              src_c   [STAGES];
    logic              src_sat [STAGES];
    logic [WIDTH-1:0]  n_s     [STAGES];
    logic              n_c     [STAGES];
    logic              n_ov    [STAGES];

    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic              go;
    logic              sat_in;
    logic [SW:0]       slice;

`ifdef PIPELINED_ADDER_SAT_EN
    assign sat_in = sat;
`else
    assign sat_in = 1'b0;
`endif

    // One 4-bit carry-lookahead group: returns {carry_out, sum}
    function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic [3:0] p;
        logic [3:0] g;
        logic [3:0] c;
        logic       co;
        p    = x ^ y;
        g    = x & y;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        return {co, p ^ c};
    endfunction

    // Slice adder: CLA groups chained by their group carries
    function automatic logic [SW:0] add_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                              input logic ci);
        logic [SW-1:0] s;
        logic          c;
        logic [4:0]    grp;
        s = '0;
        c = ci;
        for (int unsigned i = 0; i < GROUPS; i++) begin
            grp         = cla4(x[i*4 +: 4], y[i*4 +: 4], c);
            s[i*4 +: 4] = grp[3:0];
            c           = grp[4];
        end
        return {c, s};
    endfunction

    // Handshake: advance from the output stage backwards; a stage moves if the next slot frees
    always_comb begin
        adv  = '0;
        load = '0;
        go   = out_ready;
        for (int k = int'(STAGES) - 1; k >= 0; k--) begin
            adv[k] = v[k] & go;
            go     = ~v[k] | adv[k];
        end
        in_ready = go;
        load[0]  = in_valid & go;
        for (int unsigned k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end
    end

    // Stage inputs: stage 0 from the ports (B pre-inverted for subtract), later stages from registers
    always_comb begin
        src_a[0]   = a;
        src_b[0]   = b ^ {WIDTH{sub}};
        src_s[0]   = '0;
        src_c[0]   = sub;
        src_sat[0] = sat_in;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_a[k]   = a_q[k-1];
            src_b[k]   = b_q[k-1];
            src_s[k]   = s_q[k-1];
            src_c[k]   = c_q[k-1];
            src_sat[k] = sat_q[k-1];
        end
    end

    // Slice arithmetic per stage; the last stage also derives overflow and saturation
    always_comb begin
        slice = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            slice               = add_slice(src_a[k][k*SW +: SW], src_b[k][k*SW +: SW], src_c[k]);
            n_s[k]              = src_s[k];
            n_s[k][k*SW +: SW]  = slice[SW-1:0];
            n_c[k]              = slice[SW];
            n_ov[k]             = 1'b0;
            if (k == STAGES - 1) begin
                n_ov[k] = (src_a[k][WIDTH-1] == src_b[k][WIDTH-1]) &&
                          (n_s[k][WIDTH-1] != src_a[k][WIDTH-1]);
                if (src_sat[k] && n_ov[k]) begin
                    n_s[k] = src_a[k][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
        end
    end

    // Stage registers: load on transfer into the stage, clear valid when it empties
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                ov_q[k]  <= 1'b0;
                sat_q[k] <= 1'b0;
            end
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v[k]     <= 1'b1;
                    a_q[k]   <= src_a[k];
                    b_q[k]   <= src_b[k];
                    s_q[k]   <= n_s[k];
                    c_q[k]   <= n_c[k];
                    ov_q[k]  <= n_ov[k];
                    sat_q[k] <= src_sat[k];
                end else if (adv[k]) begin
                    v[k] <= 1'b0;
                end
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry     = c_q[STAGES-1];
    assign overflow  = ov_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=32, STAGES=2, default build).
module tb_pipelined_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        carry;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        o;
    } res_t;

    res_t exp_q[$];

    pipelined_adder #(.WIDTH(32), .STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Reference: plain integer arithmetic on the operands
    function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic s);
        res_t        r;
        longint      sx;
        longint      sy;
        longint      sr;
        logic [32:0] t;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        sr = s ? (sx - sy) : (sx + sy);
        r.o = (longint'($signed(sr[31:0])) != sr);
        if (s) begin
            r.s = x - y;
            r.c = (x >= y);
        end else begin
            t   = {1'b0, x} + {1'b0, y};
            r.s = t[31:0];
            r.c = t[32];
        end
        return r;
    endfunction

    function automatic logic [31:0] pick_operand();
        int unsigned sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, input logic ordy);
        @(negedge clk);
        in_valid  = iv;
        a         = ia;
        b         = ib;
        sub       = isub;
        out_ready = ordy;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++;
        if (sum !== 32'h0) begin errors++; $display("FAIL reset_sum: got %h want 0", sum); end
        checks++;
        if ({carry, overflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {carry, overflow}); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_directed();
        logic [31:0] va   [6];
        logic [31:0] vb   [6];
        logic        vsub [6];
        logic [31:0] vs   [6];
        logic        vc   [6];
        logic        vo   [6];
        int          lat;
        logic        seen;
        va   = '{32'h0000FFFF, 32'h7FFFFFFF, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 32'h80000000};
        vb   = '{32'h00000001, 32'h00000001, 32'h00000001, 32'h00000003, 32'h00000001, 32'h00000001};
        vsub = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vs   = '{32'h00010000, 32'h80000000, 32'hFFFFFFFF, 32'h00000002, 32'h00000000, 32'h7FFFFFFF};
        vc   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        vo   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, va[i], vb[i], vsub[i], 1'b1);
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL dir%0d_in_ready: got %b want 1", i, in_ready); end
            lat  = 0;
            seen = 1'b0;
            while (!seen && lat < 10) begin
                drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
                lat++;
                if (out_valid === 1'b1) seen = 1'b1;
            end
            checks++;
            if (!seen || lat != 2) begin errors++; $display("FAIL dir%0d_latency: got %0d cycles (seen=%b) want 2", i, lat, seen); end
            checks++;
            if (sum !== vs[i]) begin errors++; $display("FAIL dir%0d_sum: got %h want %h", i, sum, vs[i]); end
            checks++;
            if (carry !== vc[i]) begin errors++; $display("FAIL dir%0d_carry: got %b want %b", i, carry, vc[i]); end
            checks++;
            if (overflow !== vo[i]) begin errors++; $display("FAIL dir%0d_overflow: got %b want %b", i, overflow, vo[i]); end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        int   sent;
        int   got;
        int   i;
        logic ordy;
        res_t r;
        exp_q.delete();
        sent = 0;
        got  = 0;
        i    = 0;
        while ((sent < 10 || exp_q.size() > 0) && i < 60) begin
            ordy = !(i >= 3 && i <= 7);
            drive(sent < 10, $urandom, $urandom, 1'($urandom_range(0, 1)), ordy);
            if (i >= 3 && i <= 7) begin
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_stall_in_ready c%0d: got %b want 0", i, in_ready); end
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_stall_out_valid c%0d: got %b want 1", i, out_valid); end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_stall_hold c%0d: got empty model queue want head", i);
                end else if ({sum, carry, overflow} !== exp_q[0]) begin
                    errors++; $display("FAIL b2b_stall_hold c%0d: got %h want %h", i, {sum, carry, overflow}, exp_q[0]);
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_beat c%0d: got unexpected %h want none", i, sum);
                end else begin
                    r = exp_q.pop_front();
                    got++;
                    if ({sum, carry, overflow} !== r) begin
                        errors++; $display("FAIL b2b_result c%0d: got %h want %h", i, {sum, carry, overflow}, r);
                    end
                end
            end
            i++;
        end
        checks++;
        if (sent != 10 || got != 10 || exp_q.size() != 0) begin
            errors++; $display("FAIL b2b_count: got sent=%0d out=%0d left=%0d want 10/10/0", sent, got, exp_q.size());
        end
    endtask

    task automatic test_random();
        int   n;
        int   sent;
        int   got;
        int   cyc;
        logic iv;
        logic ordy;
        res_t r;
        n    = 10000;
        sent = 0;
        got  = 0;
        cyc  = 0;
        exp_q.delete();
        while ((sent < n || exp_q.size() > 0) && cyc < 40000) begin
            iv   = (sent < n) && ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            drive(iv, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)), ordy);
            checks++;
            if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
                errors++; $display("FAIL rnd_in_ready c%0d: got %b want %b", cyc, in_ready, (exp_q.size() < 2) || out_ready);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, sub));
                sent++;
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rnd_extra_beat c%0d: got unexpected %h want none", cyc, sum);
                end else begin
                    r = exp_q.pop_front();
                    got++;
                    if ({sum, carry, overflow} !== r) begin
                        errors++; $display("FAIL rnd_result c%0d: got %h want %h", cyc, {sum, carry, overflow}, r);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (sent != n || got != n || exp_q.size() != 0) begin
            errors++; $display("FAIL rnd_count: got sent=%0d out=%0d left=%0d want %0d/%0d/0", sent, got, exp_q.size(), n, n);
        end
    endtask

    task automatic test_reset_midflight();
        drive(1'b1, 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        drive(1'b1, 32'h0000_0010, 32'h0000_0001, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_out_valid: got %b want 1", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_pre_in_ready: got %b want 0", in_ready); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_async_clear: got %b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale_beat c%0d: got %b want 0", i, out_valid); end
            checks++;
            if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready c%0d: got %b want 1", i, in_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
